// File: rtl/fir_pkg.sv
// Constants and FSM state encoding shared by the DA LUT loader, its adder
// sub-module and the testbench.
package fir_pkg;

  localparam int NTAPS = 64;
  localparam int GRP   = 8;
  localparam int CW    = 16;
  localparam int OW    = 19;
  localparam int AW    = 11;
  localparam int TAPW  = 6;
  localparam int GW    = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/da_group_sum.sv
// Conditional sum of one 8-tap coefficient group, selected bit-by-bit by the
// LUT address pattern. Purely combinational.
module da_group_sum
  import fir_pkg::*;
(
  input  logic [GRP-1:0]         pattern,
  input  logic [GRP-1:0][CW-1:0] coefs,
  output logic signed [OW-1:0]   sum
);

  logic signed [OW-1:0] term [GRP];
  logic signed [OW-1:0] lvl1 [GRP/2];
  logic signed [OW-1:0] lvl2 [GRP/4];

  always_comb begin
    for (int b = 0; b < GRP; b++) begin
      term[b] = pattern[b] ? {{(OW-CW){coefs[b][CW-1]}}, coefs[b]} : '0;
    end
    for (int i = 0; i < GRP/2; i++) begin
      lvl1[i] = term[2*i] + term[2*i+1];
    end
    for (int i = 0; i < GRP/4; i++) begin
      lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    end
    sum = lvl2[0] + lvl2[1];
  end

endmodule

// File: rtl/da_lut_loader.sv
// Collects 64 FIR coefficients over a valid/ready stream, then streams all
// 2048 distributed-arithmetic partial sums to fir_filter, one per clock.
//
// state    | meaning
// IDLE     | waiting for start
// COLLECT  | accepting coefficients into coef_mem
// WRITE    | emitting LUT entries 0..2047
// DONE     | CLOAD drops, done pulses, back to IDLE
module da_lut_loader
  import fir_pkg::*;
(
  input  logic                 clk_slow,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [CW-1:0] coef_in,
  input  logic                 coef_valid,
  output logic                 coef_ready,
  output logic signed [OW-1:0] CIN,
  output logic [AW-1:0]        CADDR,
  output logic                 CLOAD,
  output logic                 busy,
  output logic                 done
);

  logic [1:0]      state_q, state_d;
  logic [TAPW-1:0] tap_q, tap_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            coef_ready_q, coef_ready_d;
  logic [OW-1:0]   cin_q, cin_d;
  logic [AW-1:0]   caddr_q, caddr_d;
  logic            cload_q, cload_d;
  logic            done_q, done_d;

  logic [CW-1:0]          coef_mem [NTAPS];
  logic [GRP-1:0][CW-1:0] grp_coefs;
  logic signed [OW-1:0]   entry;
  logic                   accept;

  // coef_ready_q is only ever high in COLLECT, so this is the full handshake.
  assign accept = coef_valid & coef_ready_q;

  // Coefficient storage carries no reset; every sequence rewrites all 64.
  always_ff @(posedge clk_slow) begin
    if (accept) coef_mem[tap_q] <= coef_in;
  end

  always_comb begin
    for (int b = 0; b < GRP; b++) begin
      grp_coefs[b] = coef_mem[{cnt_q[AW-1:AW-GW], b[GW-1:0]}];
    end
  end

  da_group_sum u_group_sum (
    .pattern (cnt_q[GRP-1:0]),
    .coefs   (grp_coefs),
    .sum     (entry)
  );

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    coef_ready_d = 1'b0;
    cin_d        = cin_q;
    caddr_d      = caddr_q;
    cload_d      = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COLLECT;
          tap_d   = '0;
        end
      end
      ST_COLLECT: begin
        coef_ready_d = 1'b1;
        if (accept) begin
          tap_d = tap_q + TAPW'(1);
          if (tap_q == TAPW'(NTAPS - 1)) begin
            state_d      = ST_WRITE;
            cnt_d        = '0;
            coef_ready_d = 1'b0;
          end
        end
      end
      ST_WRITE: begin
        caddr_d = cnt_q;
        cin_d   = entry;
        cload_d = 1'b1;
        cnt_d   = cnt_q + AW'(1);
        if (&cnt_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_slow or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tap_q        <= '0;
      cnt_q        <= '0;
      coef_ready_q <= 1'b0;
      cin_q        <= '0;
      caddr_q      <= '0;
      cload_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      coef_ready_q <= coef_ready_d;
      cin_q        <= cin_d;
      caddr_q      <= caddr_d;
      cload_q      <= cload_d;
      done_q       <= done_d;
    end
  end

  assign coef_ready = coef_ready_q;
  assign CIN        = cin_q;
  assign CADDR      = caddr_q;
  assign CLOAD      = cload_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_da_lut_loader.sv
// Directed bench for da_lut_loader: full load sequences, LUT spot values from a
// vector table, strobe/address continuity, done timing and mid-write reset.
module tb_da_lut_loader;
  import fir_pkg::*;

  logic                 clk_slow;
  logic                 reset;
  logic                 start;
  logic signed [CW-1:0] coef_in;
  logic                 coef_valid;
  logic                 coef_ready;
  logic signed [OW-1:0] CIN;
  logic [AW-1:0]        CADDR;
  logic                 CLOAD;
  logic                 busy;
  logic                 done;

  da_lut_loader dut (
    .clk_slow   (clk_slow),
    .reset      (reset),
    .start      (start),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .CIN        (CIN),
    .CADDR      (CADDR),
    .CLOAD      (CLOAD),
    .busy       (busy),
    .done       (done)
  );

  initial clk_slow = 1'b0;
  always #5 clk_slow = ~clk_slow;

  typedef struct {
    int          scen;
    logic [10:0] addr;
    logic [18:0] exp;
  } vec_t;

  vec_t        vecs [12];
  logic [15:0] coef_tab [64];
  logic [18:0] lut [2048];
  int          n_pass;
  int          n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic fill_coefs(input int kind);
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0: coef_tab[i] = 16'd1;
        1: coef_tab[i] = 16'h8000;
        2: coef_tab[i] = 16'(i);
        default: coef_tab[i] = 16'd2;
      endcase
    end
  endtask

  task automatic check_table(input int scen);
    for (int k = 0; k < 12; k++) begin
      if (vecs[k].scen == scen) begin
        check($sformatf("lut_s%0d_a%0h", scen, vecs[k].addr), 32'(lut[vecs[k].addr]), 32'(vecs[k].exp));
      end
    end
  endtask

  // Starts a sequence, feeds coef_tab, then watches the WRITE burst.
  task automatic run_seq(input int scen, input bit gap, input int pulse_at, input int abort_at);
    int idx, cyc, nload, exp_addr, addr_err, done_cnt, busy_err, done_ok, seen_done;
    bit v, prev_load;
    logic [10:0] prev_addr;
    for (int a = 0; a < 2048; a++) lut[a] = 19'h7FFFF;
    @(negedge clk_slow);
    start = 1'b1;
    @(negedge clk_slow);
    start = 1'b0;
    check($sformatf("busy_collect_s%0d", scen), 32'(busy), 32'd1);
    idx = 0; cyc = 0; v = 1'b0;
    while (idx < 64 && cyc < 400) begin
      v = gap ? ~v : 1'b1;
      coef_valid = v;
      coef_in = coef_tab[idx];
      if (v && coef_ready) idx++;
      @(negedge clk_slow);
      cyc++;
    end
    coef_valid = 1'b0;
    check($sformatf("accepts_s%0d", scen), 32'(idx), 32'd64);
    check($sformatf("ready_drop_s%0d", scen), 32'(coef_ready), 32'd0);
    nload = 0; exp_addr = 0; addr_err = 0; done_cnt = 0; busy_err = 0; done_ok = 0; seen_done = 0;
    prev_load = 1'b0; prev_addr = '0;
    for (int c = 0; c < 2100; c++) begin
      if (CLOAD) begin
        if (CADDR != 11'(exp_addr)) addr_err++;
        lut[CADDR] = CIN;
        exp_addr++;
        nload++;
        if (!busy) busy_err++;
      end
      if (done) begin
        done_cnt++;
        if (prev_load && !CLOAD && prev_addr == 11'h7FF && CADDR == 11'h7FF) done_ok = 1;
      end
      prev_load = CLOAD;
      prev_addr = CADDR;
      if (abort_at >= 0 && CLOAD && CADDR == 11'(abort_at)) begin
        reset = 1'b1;
        #1;
        check("abort_cload", 32'(CLOAD), 32'd0);
        check("abort_caddr", 32'(CADDR), 32'd0);
        check("abort_cin", 32'(CIN), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk_slow);
        reset = 1'b0;
        for (int w = 0; w < 6; w++) begin
          if (done) seen_done++;
          @(negedge clk_slow);
        end
        check("abort_no_done", 32'(seen_done + done_cnt), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        return;
      end
      start = (pulse_at >= 0 && CLOAD && CADDR == 11'(pulse_at));
      @(negedge clk_slow);
    end
    start = 1'b0;
    check($sformatf("cload_count_s%0d", scen), 32'(nload), 32'd2048);
    check($sformatf("caddr_seq_s%0d", scen), 32'(addr_err), 32'd0);
    check($sformatf("done_count_s%0d", scen), 32'(done_cnt), 32'd1);
    check($sformatf("done_timing_s%0d", scen), 32'(done_ok), 32'd1);
    check($sformatf("busy_write_s%0d", scen), 32'(busy_err), 32'd0);
    check($sformatf("idle_after_s%0d", scen), 32'(busy), 32'd0);
    check_table(scen);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    vecs[0]  = '{0, 11'h000, 19'd0};
    vecs[1]  = '{0, 11'h0FF, 19'd8};
    vecs[2]  = '{0, 11'h055, 19'd4};
    vecs[3]  = '{0, 11'h7FF, 19'd8};
    vecs[4]  = '{1, 11'h0FF, 19'h40000};
    vecs[5]  = '{1, 11'h001, 19'h78000};
    vecs[6]  = '{2, 11'h1FF, 19'd92};
    vecs[7]  = '{2, 11'h303, 19'd49};
    vecs[8]  = '{2, 11'h780, 19'd63};
    vecs[9]  = '{2, 11'h000, 19'd0};
    vecs[10] = '{5, 11'h0FF, 19'd16};
    vecs[11] = '{5, 11'h700, 19'd0};

    reset = 1'b1;
    start = 1'b0;
    coef_in = '0;
    coef_valid = 1'b0;
    @(negedge clk_slow);
    @(negedge clk_slow);
    check("rst_cload", 32'(CLOAD), 32'd0);
    check("rst_caddr", 32'(CADDR), 32'd0);
    check("rst_cin", 32'(CIN), 32'd0);
    check("rst_ready", 32'(coef_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk_slow);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(coef_ready), 32'd0);

    fill_coefs(0); run_seq(0, 1'b0, -1, -1);
    fill_coefs(1); run_seq(1, 1'b0, -1, -1);
    fill_coefs(2); run_seq(2, 1'b1, -1, -1);
    fill_coefs(0); run_seq(3, 1'b0, 500, -1);
    fill_coefs(0); run_seq(4, 1'b0, -1, 1000);
    fill_coefs(3); run_seq(5, 1'b0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
